// File: rtl/tick_bcd_counter_if.sv
// Bus between the upstream mode-select stage and the tick/BCD counter.
// The mode-select side drives period, enable and clear; the counter drives the rest.
interface tick_bcd_counter_if #(
  parameter int DIGITS = 4
);
  logic [26:0]         time_value;
  logic                allow_count;
  logic                clr;
  logic                tick;
  logic [4*DIGITS-1:0] bcd;
  logic                wrap;
  logic                running;

  modport master (
    output time_value, allow_count, clr,
    input  tick, bcd, wrap, running
  );

  modport slave (
    input  time_value, allow_count, clr,
    output tick, bcd, wrap, running
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// Programmable-period tick generator with a DIGITS-wide BCD event counter.
// A prescaler counts clk cycles in RUN, then emits a one-cycle tick and bumps the BCD value.
module tick_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tick_bcd_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t              r_state;
  logic [26:0]         r_prescaler;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_tick;
  logic                r_wrap;

  logic [26:0]         w_lastCount;
  logic                w_periodDone;
  logic [4*DIGITS-1:0] w_bcdInc;
  logic                w_rollover;

  // A zero period behaves like a period of one so the counter still ticks every cycle.
  always_comb begin
    w_lastCount  = (bus.time_value == 27'd0) ? 27'd0 : (bus.time_value - 27'd1);
    w_periodDone = (r_prescaler >= w_lastCount);
  end

  always_comb begin
    logic carry;
    carry    = 1'b1;
    w_bcdInc = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r_bcd[4*d +: 4] >= 4'd9) begin
          w_bcdInc[4*d +: 4] = 4'd0;
        end else begin
          w_bcdInc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    w_rollover = carry;
  end

  // Falling enable wins over a pending period end, leaving the prescaler parked at P-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prescaler <= 27'd0;
      r_bcd       <= '0;
      r_tick      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (bus.clr) begin
        r_state     <= IDLE;
        r_prescaler <= 27'd0;
        r_bcd       <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_prescaler <= 27'd0;
            r_bcd       <= '0;
            if (bus.allow_count) r_state <= RUN;
          end
          RUN: begin
            if (!bus.allow_count) begin
              r_state <= PAUSE;
            end else if (w_periodDone) begin
              r_prescaler <= 27'd0;
              r_tick      <= 1'b1;
              r_bcd       <= w_bcdInc;
              r_wrap      <= w_rollover;
            end else begin
              r_prescaler <= r_prescaler + 27'd1;
            end
          end
          PAUSE: begin
            if (bus.allow_count) r_state <= RUN;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;
  assign bus.bcd     = r_bcd;
  assign bus.running = (r_state == RUN);

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: period, pause, wrap, clear and async reset behaviour.
module tb_tick_bcd_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tick_bcd_counter_if #(.DIGITS(4)) bus ();

  tick_bcd_counter #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [26:0] tv, input logic allow, input logic clear);
    bus.time_value  = tv;
    bus.allow_count = allow;
    bus.clr         = clear;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear for one edge, then leave clr low with the given period and enable.
  task automatic clearThen(input logic [26:0] tv, input logic allow);
    applyStimulus(tv, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(tv, allow, 1'b0);
  endtask

  initial begin
    int ticks;
    int wraps;
    total = 0;
    bad   = 0;

    rst_n = 1'b0;
    applyStimulus(27'd0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_bcd", {16'd0, bus.bcd}, 32'h0000);
    checkOutput("rst_tick", {31'd0, bus.tick}, 32'd0);
    checkOutput("rst_wrap", {31'd0, bus.wrap}, 32'd0);
    checkOutput("rst_running", {31'd0, bus.running}, 32'd0);
    stepCycles(1);
    rst_n = 1'b1;

    // Period 3 from reset: ticks on RUN edges 3, 6, 9, 12.
    applyStimulus(27'd3, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("p3_enter_running", {31'd0, bus.running}, 32'd1);
    checkOutput("p3_enter_tick", {31'd0, bus.tick}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      stepCycles(1);
      checkOutput($sformatf("p3_tick_c%0d", i), {31'd0, bus.tick}, ((i % 3) == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("p3_bcd", {16'd0, bus.bcd}, 32'h0004);

    // Period 0 then period 1: tick every cycle.
    clearThen(27'd0, 1'b1);
    checkOutput("clr_bcd", {16'd0, bus.bcd}, 32'h0000);
    checkOutput("clr_running", {31'd0, bus.running}, 32'd0);
    stepCycles(1);
    checkOutput("p0_enter_tick", {31'd0, bus.tick}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      stepCycles(1);
      checkOutput($sformatf("p0_tick_c%0d", i), {31'd0, bus.tick}, 32'd1);
      checkOutput($sformatf("p0_bcd_c%0d", i), {16'd0, bus.bcd}, i);
    end
    applyStimulus(27'd1, 1'b1, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      stepCycles(1);
      checkOutput($sformatf("p1_tick_c%0d", i), {31'd0, bus.tick}, 32'd1);
      checkOutput($sformatf("p1_bcd_c%0d", i), {16'd0, bus.bcd}, i);
    end

    // Count up to 9999 with period 1, then roll over.
    clearThen(27'd1, 1'b1);
    stepCycles(1);
    ticks = 0;
    wraps = 0;
    for (int i = 1; i <= 9999; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
      if (bus.wrap) wraps++;
      if (i == 10)   checkOutput("carry_0010", {16'd0, bus.bcd}, 32'h0010);
      if (i == 100)  checkOutput("carry_0100", {16'd0, bus.bcd}, 32'h0100);
      if (i == 1000) checkOutput("carry_1000", {16'd0, bus.bcd}, 32'h1000);
      if (i == 1999) checkOutput("carry_1999", {16'd0, bus.bcd}, 32'h1999);
    end
    checkOutput("pre_bcd_9999", {16'd0, bus.bcd}, 32'h9999);
    checkOutput("pre_tick_count", ticks, 9999);
    checkOutput("pre_wrap_count", wraps, 0);
    stepCycles(1);
    checkOutput("wrap_bcd", {16'd0, bus.bcd}, 32'h0000);
    checkOutput("wrap_pulse", {31'd0, bus.wrap}, 32'd1);
    checkOutput("wrap_tick", {31'd0, bus.tick}, 32'd1);
    stepCycles(1);
    checkOutput("wrap_after", {31'd0, bus.wrap}, 32'd0);
    checkOutput("wrap_after_bcd", {16'd0, bus.bcd}, 32'h0001);

    // Period 10: 5 RUN edges, pause 7 edges, resume needs 5 more RUN edges.
    clearThen(27'd10, 1'b1);
    stepCycles(1);
    stepCycles(5);
    checkOutput("pause_pre_tick", {31'd0, bus.tick}, 32'd0);
    applyStimulus(27'd10, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 7; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
    end
    checkOutput("pause_ticks", ticks, 0);
    checkOutput("pause_running", {31'd0, bus.running}, 32'd0);
    checkOutput("pause_bcd", {16'd0, bus.bcd}, 32'h0000);
    applyStimulus(27'd10, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("resume_running", {31'd0, bus.running}, 32'd1);
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
    end
    checkOutput("resume_early_ticks", ticks, 0);
    stepCycles(1);
    checkOutput("resume_tick", {31'd0, bus.tick}, 32'd1);
    checkOutput("resume_bcd", {16'd0, bus.bcd}, 32'h0001);

    // Enable drops while prescaler holds P-1: tick deferred to first RUN edge after resume.
    clearThen(27'd4, 1'b1);
    stepCycles(1);
    stepCycles(3);
    applyStimulus(27'd4, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("edge_pause_tick", {31'd0, bus.tick}, 32'd0);
    applyStimulus(27'd4, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("edge_resume_tick", {31'd0, bus.tick}, 32'd0);
    stepCycles(1);
    checkOutput("edge_deferred_tick", {31'd0, bus.tick}, 32'd1);

    // Period shrinks from 100 to 20 after 50 cycles.
    clearThen(27'd100, 1'b1);
    stepCycles(1);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
    end
    checkOutput("shrink_pre_ticks", ticks, 0);
    applyStimulus(27'd20, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("shrink_tick", {31'd0, bus.tick}, 32'd1);
    ticks = 0;
    for (int i = 0; i < 19; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
    end
    checkOutput("shrink_gap_ticks", ticks, 0);
    stepCycles(1);
    checkOutput("shrink_period20", {31'd0, bus.tick}, 32'd1);

    // Period grows from 3 to 6 after one cycle: current period stretches to 6.
    clearThen(27'd3, 1'b1);
    stepCycles(1);
    stepCycles(1);
    applyStimulus(27'd6, 1'b1, 1'b0);
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycles(1);
      if (bus.tick) ticks++;
    end
    checkOutput("grow_gap_ticks", ticks, 0);
    stepCycles(1);
    checkOutput("grow_tick", {31'd0, bus.tick}, 32'd1);

    // clr coincident with the tick condition.
    clearThen(27'd2, 1'b1);
    stepCycles(1);
    stepCycles(1);
    applyStimulus(27'd2, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("clrtick_tick", {31'd0, bus.tick}, 32'd0);
    checkOutput("clrtick_wrap", {31'd0, bus.wrap}, 32'd0);
    checkOutput("clrtick_bcd", {16'd0, bus.bcd}, 32'h0000);
    checkOutput("clrtick_running", {31'd0, bus.running}, 32'd0);
    applyStimulus(27'd2, 1'b1, 1'b0);
    stepCycles(1);
    stepCycles(1);
    checkOutput("clrtick_pres_zero", {31'd0, bus.tick}, 32'd0);
    stepCycles(1);
    checkOutput("clrtick_next_tick", {31'd0, bus.tick}, 32'd1);

    // Asynchronous reset between edges while ticking.
    clearThen(27'd1, 1'b1);
    stepCycles(1);
    stepCycles(5);
    checkOutput("arst_pre_tick", {31'd0, bus.tick}, 32'd1);
    checkOutput("arst_pre_bcd", {16'd0, bus.bcd}, 32'h0005);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tick", {31'd0, bus.tick}, 32'd0);
    checkOutput("arst_bcd", {16'd0, bus.bcd}, 32'h0000);
    checkOutput("arst_running", {31'd0, bus.running}, 32'd0);
    checkOutput("arst_wrap", {31'd0, bus.wrap}, 32'd0);
    applyStimulus(27'd2, 1'b1, 1'b0);
    rst_n = 1'b1;
    stepCycles(1);
    checkOutput("arst_enter_running", {31'd0, bus.running}, 32'd1);
    checkOutput("arst_enter_bcd", {16'd0, bus.bcd}, 32'h0000);
    stepCycles(1);
    checkOutput("arst_first_notick", {31'd0, bus.tick}, 32'd0);
    stepCycles(1);
    checkOutput("arst_first_tick", {31'd0, bus.tick}, 32'd1);
    checkOutput("arst_first_bcd", {16'd0, bus.bcd}, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
